// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types for the memory-access stage
// Purpose: FSM state encoding, X/M control and data structs, and the
//          result struct handed to the M/W register.
// Contents: XLEN, REG_W, RegAddr, MemState, M_ctrl, XM_data, MW_result,
//           is_mem_op(), is_store().
package mem_access_unit_pkg;

   localparam int XLEN  = 32;
   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] RegAddr;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } MemState;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic fpu_sel;
   } M_ctrl;

   typedef struct packed {
      RegAddr            dst;
      RegAddr            fpu_dst;
      logic [XLEN-1:0]   addr;
      logic [XLEN-1:0]   alu_val;
      logic [XLEN-1:0]   fpu_val;
      logic              alu_zero;
      logic [XLEN-1:0]   pc_branch;
   } XM_data;

   typedef struct packed {
      logic            valid;
      RegAddr          dst;
      logic [XLEN-1:0] data;
      logic            fpu;
   } MW_result;

   function automatic logic is_mem_op(input M_ctrl c);
      return c.mem_read | c.mem_write;
   endfunction

   // A read+write op is a store: the write wins.
   function automatic logic is_store(input M_ctrl c);
      return c.mem_write;
   endfunction

endpackage

// File: rtl/mem_access_unit_timeout.sv
// rtl/mem_access_unit_timeout.sv - wait-cycle counter with expiry strobe
// Purpose: counts cycles spent waiting for a data-memory ack.
// Ports:  clk_i     clock
//         rst_i     synchronous active-high reset
//         en_i      count this cycle (FSM in WAIT)
//         clr_i     restart from zero (entry to WAIT)
//         expire_o  this WAIT cycle is the TIMEOUT-th one
module mem_timeout #(
   parameter int TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_o
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The count equals the index of the current WAIT cycle, so the
   // TIMEOUT-th cycle sees TIMEOUT-1.
   assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - pipeline memory stage with data-memory handshake
// Purpose: issues loads/stores from the X/M register to data memory, stalls
//          the front of the pipe while waiting, and registers the result
//          toward M/W. Optional build macro: MEM_FPU_STORE_EN (fpu_sel picks
//          fpu_val for stores and routes load results to fpu_dst).
// Ports:  clk, rst (sync, active-high), bubble (flush current op)
//         m_ctrl, xm_data                    X/M register contents
//         dmem_req/we/addr/wdata (out)       data-memory request
//         dmem_rdata/ack (in)                data-memory response
//         m_stall (out)                      hold IF..X/M
//         bus_err (out)                      sticky timeout flag
//         wb_valid/dst/data/fpu (out)        registered result toward M/W
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bubble,
   input  M_ctrl             m_ctrl,
   input  XM_data            xm_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              m_stall,
   output logic              bus_err,
   output logic              wb_valid,
   output RegAddr            wb_dst,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_fpu
);

   MemState           state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   RegAddr            dst_q, dst_d;
   logic              fpu_q, fpu_d;
   logic              flush_q, flush_d;
   logic              bus_err_q, bus_err_d;
   MW_result          wb_q, wb_d;

   logic              tmo_clr;
   logic              tmo_expire;
   logic [DATA_W-1:0] wdata_sel;
   RegAddr            dst_sel;
   logic              fpu_sel_eff;
   MW_result          pass_res;

`ifdef MEM_FPU_STORE_EN
   assign fpu_sel_eff = m_ctrl.fpu_sel;
   assign wdata_sel   = m_ctrl.fpu_sel ? DATA_W'(xm_data.fpu_val) : DATA_W'(xm_data.alu_val);
   assign dst_sel     = m_ctrl.fpu_sel ? xm_data.fpu_dst : xm_data.dst;

   logic unused_xm;
   assign unused_xm = ^{xm_data.alu_zero, xm_data.pc_branch};
`else
   assign fpu_sel_eff = 1'b0;
   assign wdata_sel   = DATA_W'(xm_data.alu_val);
   assign dst_sel     = xm_data.dst;

   logic unused_xm;
   assign unused_xm = ^{xm_data.alu_zero, xm_data.pc_branch, m_ctrl.fpu_sel,
                        xm_data.fpu_dst, xm_data.fpu_val};
`endif

   // Non-memory ops carry their ALU result in the addr field.
   always_comb begin
      pass_res       = '0;
      pass_res.valid = (xm_data.dst != '0);
      pass_res.dst   = xm_data.dst;
      pass_res.data  = xm_data.addr;
   end

   mem_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (state_q == WAIT),
      .clr_i    (tmo_clr),
      .expire_o (tmo_expire)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      dst_d      = dst_q;
      fpu_d      = fpu_q;
      flush_d    = flush_q;
      bus_err_d  = bus_err_q;
      wb_d       = '0;
      tmo_clr    = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      m_stall    = 1'b0;

      case (state_q)
         IDLE: begin
            // A flushed memory op never reaches the bus; a store must not
            // land in memory once it has been squashed.
            if (is_mem_op(m_ctrl) && !bubble && !rst) begin
               dmem_req   = 1'b1;
               dmem_we    = is_store(m_ctrl);
               dmem_addr  = DATA_W'(xm_data.addr);
               dmem_wdata = wdata_sel;
               addr_d     = DATA_W'(xm_data.addr);
               wdata_d    = wdata_sel;
               we_d       = is_store(m_ctrl);
               dst_d      = dst_sel;
               fpu_d      = fpu_sel_eff;
               flush_d    = 1'b0;
               tmo_clr    = 1'b1;
               if (dmem_ack) begin
                  state_d = RESP;
                  if (!is_store(m_ctrl)) begin
                     wb_d.valid = 1'b1;
                     wb_d.dst   = dst_sel;
                     wb_d.data  = XLEN'(dmem_rdata);
                     wb_d.fpu   = fpu_sel_eff;
                  end
               end else begin
                  m_stall = 1'b1;
                  state_d = WAIT;
               end
            end else if (!bubble && !is_mem_op(m_ctrl)) begin
               wb_d = pass_res;
            end
         end

         WAIT: begin
            dmem_req   = 1'b1;
            dmem_we    = we_q;
            dmem_addr  = addr_q;
            dmem_wdata = wdata_q;
            if (bubble) begin
               flush_d = 1'b1;
            end
            if (dmem_ack) begin
               state_d = RESP;
               if (!we_q && !(flush_q || bubble)) begin
                  wb_d.valid = 1'b1;
                  wb_d.dst   = dst_q;
                  wb_d.data  = XLEN'(dmem_rdata);
                  wb_d.fpu   = fpu_q;
               end
            end else if (tmo_expire) begin
               state_d   = IDLE;
               bus_err_d = 1'b1;
            end else begin
               m_stall = 1'b1;
            end
         end

         RESP: begin
            // The pipe advanced on the ack, so a new op is already waiting.
            // Non-memory ops flow through; a memory op is held one cycle and
            // issued from IDLE.
            state_d = IDLE;
            if (is_mem_op(m_ctrl) && !bubble) begin
               m_stall = 1'b1;
            end else if (!bubble) begin
               wb_d = pass_res;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         dst_q     <= '0;
         fpu_q     <= 1'b0;
         flush_q   <= 1'b0;
         bus_err_q <= 1'b0;
         wb_q      <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         dst_q     <= dst_d;
         fpu_q     <= fpu_d;
         flush_q   <= flush_d;
         bus_err_q <= bus_err_d;
         wb_q      <= wb_d;
      end
   end

   assign bus_err  = bus_err_q;
   assign wb_valid = wb_q.valid;
   assign wb_dst   = wb_q.dst;
   assign wb_data  = DATA_W'(wb_q.data);
   assign wb_fpu   = wb_q.fpu;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int DW  = 32;
   localparam int TMO = 15;
`ifdef MEM_FPU_STORE_EN
   localparam bit FPU_EN = 1'b1;
`else
   localparam bit FPU_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          bubble;
   M_ctrl         m_ctrl;
   XM_data        xm_data;
   logic          dmem_req;
   logic          dmem_we;
   logic [DW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_ack;
   logic          m_stall;
   logic          bus_err;
   logic          wb_valid;
   RegAddr        wb_dst;
   logic [DW-1:0] wb_data;
   logic          wb_fpu;

   int checks = 0;
   int errors = 0;

   mem_access_unit #(
      .DATA_W  (DW),
      .TIMEOUT (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bubble     (bubble),
      .m_ctrl     (m_ctrl),
      .xm_data    (xm_data),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .m_stall    (m_stall),
      .bus_err    (bus_err),
      .wb_valid   (wb_valid),
      .wb_dst     (wb_dst),
      .wb_data    (wb_data),
      .wb_fpu     (wb_fpu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      m_ctrl     = '0;
      xm_data    = '0;
      bubble     = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},   32'(dmem_req),   32'd0);
      chk({tag, "_we"},    32'(dmem_we),    32'd0);
      chk({tag, "_addr"},  dmem_addr,       32'd0);
      chk({tag, "_wdata"}, dmem_wdata,      32'd0);
      chk({tag, "_stall"}, 32'(m_stall),    32'd0);
      chk({tag, "_berr"},  32'(bus_err),    32'd0);
      chk({tag, "_wbv"},   32'(wb_valid),   32'd0);
      chk({tag, "_wbdst"}, 32'(wb_dst),     32'd0);
      chk({tag, "_wbdat"}, wb_data,         32'd0);
      chk({tag, "_wbfpu"}, 32'(wb_fpu),     32'd0);
   endtask

   // Non-memory op: result appears on wb_* the following cycle unless flushed.
   task automatic do_alu(input logic [4:0] dst, input logic [31:0] val, input bit bub);
      set_nop();
      xm_data.dst     = dst;
      xm_data.addr    = val;
      xm_data.alu_val = $urandom;
      bubble          = bub;
      #1;
      chk("alu_req",   32'(dmem_req), 32'd0);
      chk("alu_stall", 32'(m_stall),  32'd0);
      tick();
      chk("alu_wbv",   32'(wb_valid), 32'(!bub && dst != 5'd0));
      chk("alu_wbdat", wb_data,       bub ? 32'd0 : val);
      chk("alu_wbdst", 32'(wb_dst),   bub ? 32'd0 : 32'(dst));
      bubble = 1'b0;
   endtask

   // Memory op whose ack arrives `waits` cycles after the request cycle.
   // Expected: request stable every cycle, stall in every cycle before the
   // ack, result one cycle after the ack, nothing the cycle after that.
   task automatic do_mem(input string tag, input bit store, input bit both, input bit fpu,
                         input logic [4:0] dst, input logic [4:0] fdst,
                         input logic [31:0] addr, input logic [31:0] alu,
                         input logic [31:0] fval, input logic [31:0] rd,
                         input int waits, input int bub_at);
      logic [31:0] wd_exp;
      bit          flushed;
      bit          ld_ok;
      int          stalls;
      wd_exp  = (FPU_EN && fpu) ? fval : alu;
      flushed = 1'b0;
      stalls  = 0;
      set_nop();
      m_ctrl.mem_read  = !store || both;
      m_ctrl.mem_write = store;
      m_ctrl.fpu_sel   = fpu;
      xm_data.dst      = dst;
      xm_data.fpu_dst  = fdst;
      xm_data.addr     = addr;
      xm_data.alu_val  = alu;
      xm_data.fpu_val  = fval;
      dmem_rdata       = rd;
      for (int c = 0; c <= waits; c++) begin
         dmem_ack = (c == waits);
         bubble   = (c == bub_at);
         if (c == bub_at) flushed = 1'b1;
         #1;
         chk({tag, "_req"},   32'(dmem_req), 32'd1);
         chk({tag, "_we"},    32'(dmem_we),  32'(store));
         chk({tag, "_addr"},  dmem_addr,     addr);
         chk({tag, "_wdata"}, dmem_wdata,    wd_exp);
         if (m_stall) stalls++;
         tick();
      end
      set_nop();
      #1;
      ld_ok = !store && !flushed;
      chk({tag, "_stalls"}, 32'(stalls),   32'(waits));
      chk({tag, "_wbv"},    32'(wb_valid), 32'(ld_ok));
      chk({tag, "_wbdat"},  wb_data,       ld_ok ? rd : 32'd0);
      chk({tag, "_wbdst"},  32'(wb_dst),   ld_ok ? 32'((FPU_EN && fpu) ? fdst : dst) : 32'd0);
      chk({tag, "_wbfpu"},  32'(wb_fpu),   32'(ld_ok && FPU_EN && fpu));
      chk({tag, "_rsp_req"},   32'(dmem_req), 32'd0);
      chk({tag, "_rsp_stall"}, 32'(m_stall),  32'd0);
      tick();
      chk({tag, "_after_wbv"}, 32'(wb_valid), 32'd0);
   endtask

   initial begin
      int stalls;
      int reqs;
      rst = 1'b1;
      set_nop();
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk_all_zero("reset");

      // Pass-through and bubble in IDLE.
      do_alu(5'd3, 32'h0000_1234, 1'b0);
      do_alu(5'd0, 32'h0000_0777, 1'b0);
      do_alu(5'd7, 32'h0000_4321, 1'b1);

      // Load, ack after 3 WAIT cycles: stall for 4 cycles total.
      do_mem("lw", 1'b0, 1'b0, 1'b0, 5'd9, 5'd2, 32'h100, 32'h0, 32'h0,
             32'hDEAD_BEEF, 4, -1);
      // Store, zero-wait ack.
      do_mem("sw", 1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 32'h40, 32'h55, 32'h0,
             32'h0, 0, -1);
      // Zero-wait load.
      do_mem("lw0", 1'b0, 1'b0, 1'b0, 5'd12, 5'd0, 32'h80, 32'h0, 32'h0,
             32'hCAFE_F00D, 0, -1);
      // Read and write both set: behaves as store.
      do_mem("rw", 1'b1, 1'b1, 1'b0, 5'd6, 5'd0, 32'h44, 32'hA5A5, 32'h0,
             32'h1111, 2, -1);
      // Bubble mid-WAIT: bus completes, no writeback.
      do_mem("bub", 1'b0, 1'b0, 1'b0, 5'd8, 5'd0, 32'h180, 32'h0, 32'h0,
             32'h2222_3333, 5, 2);
      // FPU-selected store: data source depends on build option.
      do_mem("fsw", 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 32'h200, 32'h77, 32'h3F80_0000,
             32'h0, 0, -1);
      // FPU-selected load: destination depends on build option.
      do_mem("flw", 1'b0, 1'b0, 1'b1, 5'd10, 5'd20, 32'h204, 32'h0, 32'h0,
             32'h4000_0000, 1, -1);
      // Ack in the very last legal WAIT cycle still completes normally.
      do_mem("lwmax", 1'b0, 1'b0, 1'b0, 5'd11, 5'd0, 32'h300, 32'h0, 32'h0,
             32'h0BAD_CAFE, TMO, -1);

      // Timeout: load never acked.
      set_nop();
      m_ctrl.mem_read = 1'b1;
      xm_data.dst     = 5'd5;
      xm_data.addr    = 32'h500;
      stalls = 0;
      reqs   = 0;
      for (int c = 0; c <= TMO; c++) begin
         #1;
         if (m_stall)  stalls++;
         if (dmem_req) reqs++;
         tick();
      end
      set_nop();
      #1;
      chk("tmo_stalls", 32'(stalls),   32'(TMO));
      chk("tmo_reqs",   32'(reqs),     32'(TMO + 1));
      chk("tmo_req",    32'(dmem_req), 32'd0);
      chk("tmo_stall",  32'(m_stall),  32'd0);
      chk("tmo_berr",   32'(bus_err),  32'd1);
      chk("tmo_wbv",    32'(wb_valid), 32'd0);
      do_mem("postto", 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 32'h600, 32'h0, 32'h0,
             32'h1357_9BDF, 1, -1);
      do_alu(5'd2, 32'h99, 1'b0);
      chk("berr_sticky", 32'(bus_err), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk_all_zero("berr_rst");

      // Reset during WAIT, then a late ack.
      set_nop();
      m_ctrl.mem_read = 1'b1;
      xm_data.dst     = 5'd13;
      xm_data.addr    = 32'h700;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_nop();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFEED_FACE;
      #1;
      chk_all_zero("rstwait");
      tick();
      dmem_ack = 1'b0;
      chk("late_wbv",   32'(wb_valid), 32'd0);
      chk("late_wbdat", wb_data,       32'd0);
      chk("late_req",   32'(dmem_req), 32'd0);
      do_alu(5'd15, 32'h0000_ABCD, 1'b0);

      // Randomized mix of ALU ops, loads and stores.
      for (int i = 0; i < 24; i++) begin
         int kind;
         int w;
         int b;
         kind = int'($urandom_range(0, 2));
         if (kind == 0) begin
            do_alu(5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) == 0));
         end else begin
            w = int'($urandom_range(0, 6));
            b = (w > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, w)) : -1;
            do_mem("rnd", kind == 2, 1'($urandom_range(0, 1)) && kind == 2,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
                   $urandom, w, b);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
